// File: rtl/riscv_pkg.sv
// Shared types for the 5-stage RV32I-subset core: opcodes, ALU ops, pipeline registers.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_PASSB = 4'd8
  } alu_op_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    alu_op_e     alu_op;
    logic        alu_src_imm;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        branch;
    logic        branch_ne;
    logic        jal;
  } id_ex_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        regwrite;
  } mem_wb_t;

  localparam if_id_t IF_ID_NOP = '{valid: 1'b0, pc: 32'h0000_0000, instr: NOP_INSTR};

  // True when a producer that will write prod_rd feeds one of the used sources.
  function automatic logic raw_hit(input logic prod_we, input logic [4:0] prod_rd,
                                   input logic use1, input logic [4:0] rs1,
                                   input logic use2, input logic [4:0] rs2);
    return prod_we && (prod_rd != 5'd0) &&
           ((use1 && (prod_rd == rs1)) || (use2 && (prod_rd == rs2)));
  endfunction

endpackage

// File: rtl/riscv_regfile.sv
// 32x32 register file: two async read ports, one sync write port, WB->ID bypass, x0 hardwired.
module riscv_regfile (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] r_regs [32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= 32'd0;
    end else if (i_we && (i_wa != 5'd0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  always_comb begin
    if (i_ra1 == 5'd0) o_rd1 = 32'd0;
    else if (i_we && (i_wa == i_ra1)) o_rd1 = i_wd;
    else o_rd1 = r_regs[i_ra1];
  end

  always_comb begin
    if (i_ra2 == 5'd0) o_rd2 = 32'd0;
    else if (i_we && (i_wa == i_ra2)) o_rd2 = i_wd;
    else o_rd2 = r_regs[i_ra2];
  end

endmodule

// File: rtl/pipelined_riscv_core.sv
// 5-stage in-order RV32I-subset core with internal imem/dmem.
// Define PIPE_FORWARDING_EN for EX operand forwarding; otherwise ID stalls on any pending RAW.
module pipelined_riscv_core
  import riscv_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter string       IMEM_FILE  = "program.hex",
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic clock,
  input logic reset_pc
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  // imem holds the IMEM_FILE image, loaded by the environment before reset release
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [31:0] r_dmem [DMEM_DEPTH];

  logic [31:0] r_pc;
  if_id_t      r_if_id;
  id_ex_t      r_id_ex;
  ex_mem_t     r_ex_mem;
  mem_wb_t     r_mem_wb;

  logic [31:0] w_fetch;
  if_id_t      w_if_id_nxt;
  id_ex_t      w_dec;
  ex_mem_t     w_ex_mem_nxt;
  mem_wb_t     w_mem_wb_nxt;
  logic [31:0] w_instr_id, w_rd1, w_rd2;
  logic        w_legal, w_use_rs1, w_use_rs2, w_stall, w_take;
  logic [31:0] w_fwd_a, w_fwd_b, w_opb, w_alu, w_ex_res, w_target;
  logic [31:0] w_mem_rdata, w_st_data, w_wb_data;
  logic [DMEM_AW-1:0] w_st_idx;
  logic        w_st_we, w_wb_we;
  logic [4:0]  w_wb_rd;

  assign w_fetch     = r_imem[r_pc[IMEM_AW+1:2]];
  assign w_if_id_nxt = '{valid: 1'b1, pc: r_pc, instr: w_fetch};
  assign w_instr_id  = r_if_id.instr;

  riscv_regfile u_regfile (
    .i_clk (clock),
    .i_rst (reset_pc),
    .i_ra1 (w_instr_id[19:15]),
    .i_ra2 (w_instr_id[24:20]),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (w_wb_we),
    .i_wa  (w_wb_rd),
    .i_wd  (w_wb_data)
  );

  // Decode + imm-gen; anything outside the subset collapses to a bubble.
  always_comb begin
    w_dec         = '0;
    w_legal       = 1'b0;
    w_use_rs1     = 1'b0;
    w_use_rs2     = 1'b0;
    w_dec.pc      = r_if_id.pc;
    w_dec.rs1     = w_instr_id[19:15];
    w_dec.rs2     = w_instr_id[24:20];
    w_dec.rd      = w_instr_id[11:7];
    w_dec.rs1_val = w_rd1;
    w_dec.rs2_val = w_rd2;
    case (w_instr_id[6:0])
      OP_R: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.regwrite = 1'b1; w_legal = 1'b1;
        case ({w_instr_id[31:25], w_instr_id[14:12]})
          {F7_BASE, F3_ADD}: w_dec.alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}: w_dec.alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}: w_dec.alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}: w_dec.alu_op = ALU_SLT;
          {F7_BASE, F3_XOR}: w_dec.alu_op = ALU_XOR;
          {F7_BASE, F3_SRL}: w_dec.alu_op = ALU_SRL;
          {F7_BASE, F3_OR }: w_dec.alu_op = ALU_OR;
          {F7_BASE, F3_AND}: w_dec.alu_op = ALU_AND;
          default:           w_legal = 1'b0;
        endcase
      end
      OP_I: begin
        w_use_rs1 = 1'b1; w_dec.regwrite = 1'b1; w_dec.alu_src_imm = 1'b1; w_legal = 1'b1;
        w_dec.imm = {{20{w_instr_id[31]}}, w_instr_id[31:20]};
        case (w_instr_id[14:12])
          F3_ADD:  w_dec.alu_op = ALU_ADD;
          F3_SLT:  w_dec.alu_op = ALU_SLT;
          F3_XOR:  w_dec.alu_op = ALU_XOR;
          F3_OR:   w_dec.alu_op = ALU_OR;
          F3_AND:  w_dec.alu_op = ALU_AND;
          default: w_legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        w_use_rs1 = 1'b1; w_dec.regwrite = 1'b1; w_dec.memread = 1'b1; w_dec.alu_src_imm = 1'b1;
        w_dec.imm = {{20{w_instr_id[31]}}, w_instr_id[31:20]};
        w_legal   = (w_instr_id[14:12] == F3_W);
      end
      OP_STORE: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.memwrite = 1'b1; w_dec.alu_src_imm = 1'b1;
        w_dec.imm = {{20{w_instr_id[31]}}, w_instr_id[31:25], w_instr_id[11:7]};
        w_legal   = (w_instr_id[14:12] == F3_W);
      end
      OP_BRANCH: begin
        w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_dec.branch = 1'b1;
        w_dec.branch_ne = w_instr_id[12];
        w_dec.imm = {{19{w_instr_id[31]}}, w_instr_id[31], w_instr_id[7],
                     w_instr_id[30:25], w_instr_id[11:8], 1'b0};
        w_legal   = (w_instr_id[14:12] == F3_BEQ) || (w_instr_id[14:12] == F3_BNE);
      end
      OP_JAL: begin
        w_dec.jal = 1'b1; w_dec.regwrite = 1'b1; w_legal = 1'b1;
        w_dec.imm = {{11{w_instr_id[31]}}, w_instr_id[31], w_instr_id[19:12],
                     w_instr_id[20], w_instr_id[30:21], 1'b0};
      end
      OP_LUI: begin
        w_dec.regwrite = 1'b1; w_dec.alu_src_imm = 1'b1; w_dec.alu_op = ALU_PASSB; w_legal = 1'b1;
        w_dec.imm = {w_instr_id[31:12], 12'd0};
      end
      default: w_legal = 1'b0;
    endcase
    if (r_if_id.valid && w_legal) begin
      w_dec.valid = 1'b1;
    end else begin
      w_dec     = '0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
    end
  end

`ifdef PIPE_FORWARDING_EN
  assign w_stall = raw_hit(r_id_ex.valid && r_id_ex.memread, r_id_ex.rd,
                           w_use_rs1, w_dec.rs1, w_use_rs2, w_dec.rs2);

  // EX/MEM results win over MEM/WB so the youngest producer is used.
  always_comb begin
    if (r_ex_mem.valid && r_ex_mem.regwrite && (r_ex_mem.rd != 5'd0) && (r_ex_mem.rd == r_id_ex.rs1))
      w_fwd_a = r_ex_mem.alu_res;
    else if (w_wb_we && (w_wb_rd == r_id_ex.rs1)) w_fwd_a = w_wb_data;
    else w_fwd_a = r_id_ex.rs1_val;
    if (r_ex_mem.valid && r_ex_mem.regwrite && (r_ex_mem.rd != 5'd0) && (r_ex_mem.rd == r_id_ex.rs2))
      w_fwd_b = r_ex_mem.alu_res;
    else if (w_wb_we && (w_wb_rd == r_id_ex.rs2)) w_fwd_b = w_wb_data;
    else w_fwd_b = r_id_ex.rs2_val;
  end
`else
  assign w_stall = raw_hit(r_id_ex.valid && r_id_ex.regwrite, r_id_ex.rd,
                           w_use_rs1, w_dec.rs1, w_use_rs2, w_dec.rs2) ||
                   raw_hit(r_ex_mem.valid && r_ex_mem.regwrite, r_ex_mem.rd,
                           w_use_rs1, w_dec.rs1, w_use_rs2, w_dec.rs2);
  assign w_fwd_a = r_id_ex.rs1_val;
  assign w_fwd_b = r_id_ex.rs2_val;
`endif

  assign w_opb = r_id_ex.alu_src_imm ? r_id_ex.imm : w_fwd_b;

  always_comb begin
    case (r_id_ex.alu_op)
      ALU_ADD:   w_alu = w_fwd_a + w_opb;
      ALU_SUB:   w_alu = w_fwd_a - w_opb;
      ALU_AND:   w_alu = w_fwd_a & w_opb;
      ALU_OR:    w_alu = w_fwd_a | w_opb;
      ALU_XOR:   w_alu = w_fwd_a ^ w_opb;
      ALU_SLT:   w_alu = {31'd0, ($signed(w_fwd_a) < $signed(w_opb))};
      ALU_SLL:   w_alu = w_fwd_a << w_opb[4:0];
      ALU_SRL:   w_alu = w_fwd_a >> w_opb[4:0];
      ALU_PASSB: w_alu = w_opb;
      default:   w_alu = 32'd0;
    endcase
  end

  assign w_ex_res = r_id_ex.jal ? (r_id_ex.pc + 32'd4) : w_alu;
  assign w_target = r_id_ex.pc + r_id_ex.imm;
  assign w_take   = r_id_ex.valid &&
                    (r_id_ex.jal || (r_id_ex.branch && ((w_fwd_a == w_fwd_b) ^ r_id_ex.branch_ne)));

  assign w_ex_mem_nxt = '{valid: r_id_ex.valid, alu_res: w_ex_res, store_data: w_fwd_b,
                          rd: r_id_ex.rd, regwrite: r_id_ex.regwrite,
                          memread: r_id_ex.memread, memwrite: r_id_ex.memwrite};

  assign w_st_idx     = r_ex_mem.alu_res[DMEM_AW+1:2];
  assign w_st_we      = r_ex_mem.valid && r_ex_mem.memwrite;
  assign w_st_data    = r_ex_mem.store_data;
  assign w_mem_rdata  = r_dmem[w_st_idx];
  assign w_mem_wb_nxt = '{valid: r_ex_mem.valid,
                          wb_data: r_ex_mem.memread ? w_mem_rdata : r_ex_mem.alu_res,
                          rd: r_ex_mem.rd, regwrite: r_ex_mem.regwrite};

  assign w_wb_we   = r_mem_wb.valid && r_mem_wb.regwrite && (r_mem_wb.rd != 5'd0);
  assign w_wb_rd   = r_mem_wb.rd;
  assign w_wb_data = r_mem_wb.wb_data;

  // A taken branch in EX flushes the two younger stages even if ID wanted to stall.
  always_ff @(posedge clock or posedge reset_pc) begin
    if (reset_pc) begin
      r_pc     <= RESET_PC;
      r_if_id  <= IF_ID_NOP;
      r_id_ex  <= '0;
      r_ex_mem <= '0;
      r_mem_wb <= '0;
    end else begin
      r_ex_mem <= w_ex_mem_nxt;
      r_mem_wb <= w_mem_wb_nxt;
      if (w_take) begin
        r_pc    <= w_target;
        r_if_id <= IF_ID_NOP;
        r_id_ex <= '0;
      end else if (w_stall) begin
        r_id_ex <= '0;
      end else begin
        r_pc    <= r_pc + 32'd4;
        r_if_id <= w_if_id_nxt;
        r_id_ex <= w_dec;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_st_we) r_dmem[w_st_idx] <= w_st_data;
  end

endmodule

// File: tb/tb_pipelined_riscv_core.sv
// Scoreboard bench: expected register/memory write events are queued, a monitor pops them.
module tb_pipelined_riscv_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   armed = 1'b0;

  typedef struct packed {
    logic        st;
    logic [7:0]  idx;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  ev_cyc[64];
  int  ev_n = 0;
  logic [31:0] prog [38];

  pipelined_riscv_core #(
    .IMEM_DEPTH (256),
    .DMEM_DEPTH (256),
    .IMEM_FILE  (""),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clock    (clk),
    .reset_pc (rst)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'h37};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
    exp_q.push_back('{st: 1'b0, idx: {3'd0, rd}, data: data});
  endtask
  task automatic push_st(input logic [7:0] idx, input logic [31:0] data);
    exp_q.push_back('{st: 1'b1, idx: idx, data: data});
  endtask

  task automatic check_ev(input logic st, input logic [7:0] idx, input logic [31:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event st=%0d idx=%0d data=%h", st, idx, data);
    end else begin
      e = exp_q.pop_front();
      if ((e.st !== st) || (e.idx !== idx) || (e.data !== data)) begin
        errors++;
        $display("FAIL event%0d got st=%0d idx=%0d data=%h expected st=%0d idx=%0d data=%h",
                 ev_n, st, idx, data, e.st, e.idx, e.data);
      end
      if (ev_n < 64) ev_cyc[ev_n] = cyc;
      ev_n++;
    end
  endtask

  // Older instruction (WB) is checked before the younger store in MEM.
  always @(negedge clk) begin
    if (armed) begin
      if (dut.w_wb_we) check_ev(1'b0, {3'd0, dut.w_wb_rd}, dut.w_wb_data);
      if (dut.w_st_we) check_ev(1'b1, dut.w_st_idx, dut.w_st_data);
    end
  end

  initial begin
    int nz;
    int gap_raw;
    int gap_lu;

    prog[0]  = enc_i(12'd5,     5'd0,  3'b000, 5'd1,  7'h13);
    prog[1]  = enc_i(12'hFFD,   5'd0,  3'b000, 5'd2,  7'h13);
    prog[2]  = enc_r(7'h00, 5'd2,  5'd1,  3'b000, 5'd3);
    prog[3]  = enc_r(7'h20, 5'd2,  5'd1,  3'b000, 5'd4);
    prog[4]  = enc_r(7'h00, 5'd1,  5'd2,  3'b010, 5'd5);
    prog[5]  = enc_i(12'd7,     5'd0,  3'b000, 5'd1,  7'h13);
    prog[6]  = enc_r(7'h00, 5'd1,  5'd1,  3'b000, 5'd2);
    prog[7]  = enc_r(7'h00, 5'd1,  5'd2,  3'b000, 5'd3);
    prog[8]  = enc_s(12'd8, 5'd2, 5'd0);
    prog[9]  = enc_i(12'd8,     5'd0,  3'b010, 5'd6,  7'h03);
    prog[10] = enc_r(7'h00, 5'd6,  5'd6,  3'b000, 5'd7);
    prog[11] = enc_b(13'd8, 5'd1, 5'd1, 3'b000);
    prog[12] = enc_i(12'd1,     5'd0,  3'b000, 5'd8,  7'h13);
    prog[13] = enc_j(21'd8, 5'd9);
    prog[14] = enc_i(12'd2,     5'd0,  3'b000, 5'd8,  7'h13);
    prog[15] = enc_i(12'd5,     5'd0,  3'b000, 5'd0,  7'h13);
    prog[16] = 32'hFFFF_FFFF;
    prog[17] = enc_r(7'h00, 5'd1,  5'd0,  3'b000, 5'd10);
    prog[18] = enc_u(20'h12345, 5'd11);
    prog[19] = enc_i(12'h678,   5'd11, 3'b110, 5'd12, 7'h13);
    prog[20] = enc_i(12'h0F0,   5'd12, 3'b111, 5'd13, 7'h13);
    prog[21] = enc_i(12'hFFF,   5'd13, 3'b100, 5'd14, 7'h13);
    prog[22] = enc_i(12'd0,     5'd14, 3'b010, 5'd15, 7'h13);
    prog[23] = enc_i(12'd33,    5'd0,  3'b000, 5'd17, 7'h13);
    prog[24] = enc_r(7'h00, 5'd17, 5'd1,  3'b001, 5'd16);
    prog[25] = enc_r(7'h00, 5'd17, 5'd14, 3'b101, 5'd18);
    prog[26] = enc_r(7'h00, 5'd14, 5'd12, 3'b111, 5'd19);
    prog[27] = enc_r(7'h00, 5'd1,  5'd13, 3'b110, 5'd20);
    prog[28] = enc_r(7'h00, 5'd11, 5'd12, 3'b100, 5'd21);
    prog[29] = enc_b(13'd8, 5'd1, 5'd1, 3'b001);
    prog[30] = enc_i(12'd3,     5'd0,  3'b000, 5'd22, 7'h13);
    prog[31] = enc_b(13'd8, 5'd2, 5'd1, 3'b001);
    prog[32] = enc_i(12'd9,     5'd0,  3'b000, 5'd22, 7'h13);
    prog[33] = enc_r(7'h20, 5'd1,  5'd0,  3'b000, 5'd23);
    prog[34] = enc_i(12'd8,     5'd0,  3'b010, 5'd24, 7'h03);
    prog[35] = enc_s(12'd1028, 5'd23, 5'd0);
    prog[36] = enc_i(12'd4,     5'd0,  3'b010, 5'd25, 7'h03);
    prog[37] = enc_b(13'd0, 5'd0, 5'd0, 3'b000);

    for (int i = 0; i < 256; i++) dut.r_imem[i] = 32'h0000_0013;
    for (int i = 0; i < 38; i++) dut.r_imem[i] = prog[i];

    push_wb(5'd1, 32'd5);           push_wb(5'd2, 32'hFFFF_FFFD);
    push_wb(5'd3, 32'd2);           push_wb(5'd4, 32'd8);
    push_wb(5'd5, 32'd1);           push_wb(5'd1, 32'd7);
    push_wb(5'd2, 32'd14);          push_wb(5'd3, 32'd21);
    push_st(8'd2, 32'd14);          push_wb(5'd6, 32'd14);
    push_wb(5'd7, 32'd28);          push_wb(5'd9, 32'd56);
    push_wb(5'd10, 32'd7);          push_wb(5'd11, 32'h1234_5000);
    push_wb(5'd12, 32'h1234_5678);  push_wb(5'd13, 32'h0000_0070);
    push_wb(5'd14, 32'hFFFF_FF8F);  push_wb(5'd15, 32'd1);
    push_wb(5'd17, 32'd33);         push_wb(5'd16, 32'd14);
    push_wb(5'd18, 32'h7FFF_FFC7);  push_wb(5'd19, 32'h1234_5608);
    push_wb(5'd20, 32'h0000_0077);  push_wb(5'd21, 32'h0000_0678);
    push_wb(5'd22, 32'd3);          push_wb(5'd23, 32'hFFFF_FFF9);
    push_wb(5'd24, 32'd14);         push_st(8'd1, 32'hFFFF_FFF9);
    push_wb(5'd25, 32'hFFFF_FFF9);

    repeat (10) @(negedge clk);
    chk("reset_pc", dut.r_pc, 32'h0000_0000);
    chk("reset_wb_idle", {31'd0, dut.w_wb_we}, 32'd0);
    armed = 1'b1;
    rst   = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      chk("pc_step", dut.r_pc, 32'(k * 4));
    end

    for (int n = 0; (n < 400) && (exp_q.size() != 0); n++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

`ifdef PIPE_FORWARDING_EN
    gap_raw = 1;
    gap_lu  = 2;
`else
    gap_raw = 3;
    gap_lu  = 3;
`endif
    chk("raw_gap", 32'(ev_cyc[6] - ev_cyc[5]), 32'(gap_raw));
    chk("loaduse_gap", 32'(ev_cyc[10] - ev_cyc[9]), 32'(gap_lu));
    chk("branch_gap", 32'(ev_cyc[11] - ev_cyc[10]), 32'd4);
    chk("x8_skipped", dut.u_regfile.r_regs[8], 32'd0);
    chk("x22_bne", dut.u_regfile.r_regs[22], 32'd3);
    chk("x1_final", dut.u_regfile.r_regs[1], 32'd7);
    chk("dmem2", dut.r_dmem[2], 32'd14);
    chk("dmem1_wrap", dut.r_dmem[1], 32'hFFFF_FFF9);

    armed = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrun_reset_pc", dut.r_pc, 32'h0000_0000);
    nz = 0;
    for (int k = 1; k < 32; k++) if (dut.u_regfile.r_regs[k] != 32'd0) nz++;
    chk("midrun_reset_regs", 32'(nz), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_pc4", dut.r_pc, 32'd4);
    @(posedge clk);
    #1;
    chk("restart_pc8", dut.r_pc, 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
